// File: rtl/pipelined_shifter_pkg.sv
// shifter_pkg: shared constants for pipelined_shifter.
//   SH_OP_W / SH_LSL..SH_RRX : operation encoding on in_op (5..7 are illegal)
//   amt_cls_e                : shift-amount class decided in S1
package shifter_pkg;

    localparam int SH_OP_W = 3;

    localparam logic [SH_OP_W-1:0] SH_LSL = 3'd0;
    localparam logic [SH_OP_W-1:0] SH_LSR = 3'd1;
    localparam logic [SH_OP_W-1:0] SH_ASR = 3'd2;
    localparam logic [SH_OP_W-1:0] SH_ROR = 3'd3;
    localparam logic [SH_OP_W-1:0] SH_RRX = 3'd4;

    // Amount relative to WIDTH: zero, below, equal, above.
    typedef enum logic [1:0] {
        AMT_ZERO = 2'd0,
        AMT_LT   = 2'd1,
        AMT_EQ   = 2'd2,
        AMT_GT   = 2'd3
    } amt_cls_e;

endpackage

// File: rtl/pipelined_shifter_if.sv
// pipelined_shifter_if: request/result bundle of the pipelined shifter.
//   master : requester side (drives in_*, out_ready; sees in_ready, out_*)
//   slave  : shifter side
// Optional macro PIPELINED_SHIFTER_FLAGS_EN adds out_n / out_z.
interface pipelined_shifter_if
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 8,
    parameter int TAG_W   = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_amount;
    logic [SH_OP_W-1:0] in_op;
    logic               in_carry;
    logic [TAG_W-1:0]   in_tag;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_carry;
    logic               out_err;
    logic [TAG_W-1:0]   out_tag;
`ifdef PIPELINED_SHIFTER_FLAGS_EN
    logic               out_n;
    logic               out_z;

    modport master (
        output in_valid, in_data, in_amount, in_op, in_carry, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_err, out_tag, out_n, out_z
    );
    modport slave (
        input  in_valid, in_data, in_amount, in_op, in_carry, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_err, out_tag, out_n, out_z
    );
`else
    modport master (
        output in_valid, in_data, in_amount, in_op, in_carry, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_err, out_tag
    );
    modport slave (
        input  in_valid, in_data, in_amount, in_op, in_carry, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_err, out_tag
    );
`endif
endinterface

// File: rtl/pipelined_shifter_pipe_slice.sv
// pipe_slice: one valid/ready register stage, no skid buffer.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload
// in_ready is combinational from out_ready so the stage refills on the same
// edge it drains.
module pipe_slice #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
        end
    end
endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: 2-stage LSL/LSR/ASR/ROR/RRX shifter with ARM carry-out.
//   clk, rst_n : clock, async active-low reset
//   bus        : pipelined_shifter_if.slave (in_* request, out_* result)
// S1 registers the decoded request (amount class, amount mod WIDTH, legality,
// operand, carry, tag); S2 registers the barrel result and carry.
// Optional macro PIPELINED_SHIFTER_FLAGS_EN adds registered out_n / out_z.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 8,
    parameter int TAG_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_shifter_if.slave    bus
);
    localparam int LW  = $clog2(WIDTH);
    localparam int P1W = WIDTH + 1 + TAG_W + SH_OP_W + 2 + LW + 1;
`ifdef PIPELINED_SHIFTER_FLAGS_EN
    localparam int FW  = 2;
`else
    localparam int FW  = 0;
`endif
    localparam int P2W = WIDTH + 1 + 1 + TAG_W + FW;

    // ---------------- S1 decode ----------------
    amt_cls_e        cls;
    logic [LW-1:0]   r_in;
    logic            err_in;

    assign r_in   = bus.in_amount[LW-1:0];
    assign err_in = bus.in_op > SH_RRX;

    always_comb begin
        cls = AMT_GT;
        if (bus.in_amount == '0)                     cls = AMT_ZERO;
        else if (bus.in_amount < SHAMT_W'(WIDTH))    cls = AMT_LT;
        else if (bus.in_amount == SHAMT_W'(WIDTH))   cls = AMT_EQ;
    end

    logic           s1_valid, s1_ready, s2_ready;
    logic [P1W-1:0] s1_q;

    pipe_slice #(.PW(P1W)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (s1_ready),
        .in_data   ({bus.in_data, bus.in_carry, bus.in_tag, bus.in_op, cls, r_in, err_in}),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_q)
    );

    assign bus.in_ready = s1_ready;

    logic [WIDTH-1:0]   s1_d;
    logic               s1_c;
    logic [TAG_W-1:0]   s1_tag;
    logic [SH_OP_W-1:0] s1_op;
    logic [1:0]         s1_cls;
    logic [LW-1:0]      s1_r;
    logic               s1_err;

    assign {s1_d, s1_c, s1_tag, s1_op, s1_cls, s1_r, s1_err} = s1_q;

    // ---------------- S2 datapath ----------------
    // log2(WIDTH) mux levels; each level shifts by 2**i when bit i of r is set.
    logic [WIDTH-1:0]        shl, shr, ror;
    logic signed [WIDTH-1:0] sar;

    always_comb begin
        shl = s1_d;
        shr = s1_d;
        sar = $signed(s1_d);
        ror = s1_d;
        for (int i = 0; i < LW; i++) begin
            if (s1_r[i]) begin
                shl = shl << (1 << i);
                shr = shr >> (1 << i);
                sar = sar >>> (1 << i);
                ror = (ror >> (1 << i)) | (ror << (WIDTH - (1 << i)));
            end
        end
    end

    // Carry indices: last bit shifted out. For LSL that is d[W-r], i.e. -r mod W.
    logic [LW-1:0] idx_rm1, idx_lsl;
    assign idx_rm1 = s1_r - LW'(1);
    assign idx_lsl = LW'(0) - s1_r;

    logic [WIDTH-1:0] res_d;
    logic             res_c;

    always_comb begin
        res_d = s1_d;
        res_c = s1_c;
        if (s1_err) begin
            res_d = s1_d;
        end else if (s1_op == SH_RRX) begin
            res_d = {s1_c, s1_d[WIDTH-1:1]};
            res_c = s1_d[0];
        end else if (s1_cls != AMT_ZERO) begin
            case (s1_op)
                SH_LSL: begin
                    res_d = (s1_cls == AMT_LT) ? shl : '0;
                    res_c = (s1_cls == AMT_LT) ? s1_d[idx_lsl] :
                            (s1_cls == AMT_EQ) ? s1_d[0] : 1'b0;
                end
                SH_LSR: begin
                    res_d = (s1_cls == AMT_LT) ? shr : '0;
                    res_c = (s1_cls == AMT_LT) ? s1_d[idx_rm1] :
                            (s1_cls == AMT_EQ) ? s1_d[WIDTH-1] : 1'b0;
                end
                SH_ASR: begin
                    res_d = (s1_cls == AMT_LT) ? sar : {WIDTH{s1_d[WIDTH-1]}};
                    res_c = (s1_cls == AMT_LT) ? s1_d[idx_rm1] : s1_d[WIDTH-1];
                end
                default: begin // SH_ROR; a multiple of WIDTH leaves data, carry = msb
                    res_d = ror;
                    res_c = (s1_r == '0) ? s1_d[WIDTH-1] : s1_d[idx_rm1];
                end
            endcase
        end
    end

    logic [P2W-1:0] s2_in, s2_q;
`ifdef PIPELINED_SHIFTER_FLAGS_EN
    assign s2_in = {res_d, res_c, s1_err, s1_tag, res_d[WIDTH-1], res_d == '0};
    assign {bus.out_data, bus.out_carry, bus.out_err, bus.out_tag, bus.out_n, bus.out_z} = s2_q;
`else
    assign s2_in = {res_d, res_c, s1_err, s1_tag};
    assign {bus.out_data, bus.out_carry, bus.out_err, bus.out_tag} = s2_q;
`endif

    pipe_slice #(.PW(P2W)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (s2_q)
    );
endmodule
